// File: rtl/axi_pkg.sv
// Shared AXI write-side types: response codes and write-sequencer states.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } wr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first set request at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int i = 0; i < N; i++) begin
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI write port between N_REQ requesters, one AW/W/B transaction at a time.
// Latency: accept to done_o is 3 cycles with a zero-wait slave; at most one write per 4 cycles.
// Backpressure: AW and W hold valid/payload until accepted; bready_o is held high in RESP.
module axi_wr_arbiter
    import axi_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]    req_data_i,
    input  logic [N_REQ*STRB_W-1:0]    req_strb_i,
    output logic [N_REQ-1:0]           done_o,
    output logic [1:0]                 resp_o,
    output logic [ID_W-1:0]            awid_o,
    output logic [ADDR_W-1:0]          awaddr_o,
    output logic                       awvalid_o,
    input  logic                       awready_i,
    output logic [DATA_W-1:0]          wdata_o,
    output logic [STRB_W-1:0]          wstrb_o,
    output logic                       wvalid_o,
    input  logic                       wready_i,
    input  logic [ID_W-1:0]            bid_i,
    input  logic [1:0]                 bresp_i,
    input  logic                       bvalid_i,
    output logic                       bready_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    wr_state_t          state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [STRB_W-1:0]  strb_q, strb_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic [N_REQ-1:0]   done_q, done_d;
    resp_t              resp_q, resp_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               can_grant;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req (req_valid_i),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // No grant while reset is held or while the previous completion pulse is out.
    assign can_grant   = areset && (state_q == IDLE) && !(|done_q);
    assign req_ready_o = (can_grant && arb_any) ? arb_gnt : '0;

    assign awid_o    = ID_W'(gidx_q);
    assign awaddr_o  = addr_q;
    assign wdata_o   = data_q;
    assign wstrb_o   = strb_q;
    assign awvalid_o = awvalid_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;
    assign done_o    = done_q;
    assign resp_o    = resp_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        done_d    = '0;
        resp_d    = resp_q;
        case (state_q)
            IDLE: begin
                if (can_grant && arb_any) begin
                    gidx_d    = arb_idx;
                    addr_d    = req_addr_i[int'(arb_idx) * ADDR_W +: ADDR_W];
                    data_d    = req_data_i[int'(arb_idx) * DATA_W +: DATA_W];
                    strb_d    = req_strb_i[int'(arb_idx) * STRB_W +: STRB_W];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = XFER;
                end
            end
            XFER: begin
                // AW and W complete independently; leave once both have been taken.
                if (awready_i) awvalid_d = 1'b0;
                if (wready_i)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bvalid_i && bready_q) begin
                    bready_d       = 1'b0;
                    done_d[gidx_q] = 1'b1;
                    resp_d         = (bid_i == awid_o) ? resp_t'(bresp_i) : SLVERR;
                    ptr_d          = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= '0;
            resp_q    <= OKAY;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
        end
    end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
Shares the single AXI write port of s_axi_reg between N_REQ simple requesters.
- Each requester presents an address/data/strobe word.
- A round-robin arbiter picks one requester and runs one full AW/W/B transaction to the slave.
- The write response is returned to the winning requester.
- Only one transaction is outstanding at a time; the block sits between client logic and s_axi_reg.

Parameters:
N_REQ, 4, number of requesters (2..16)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width STRB_W = DATA_W/8
ID_W, 4, AXI ID width; must satisfy 2**ID_W >= N_REQ

Ports:
clk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  per-requester request valid; held until req_ready_o
req_ready_o  out  N_REQ  one-hot accept pulse to the granted requester
req_addr_i  in  N_REQ*ADDR_W  packed per-requester address (requester k at [k*ADDR_W +: ADDR_W])
req_data_i  in  N_REQ*DATA_W  packed per-requester write data
req_strb_i  in  N_REQ*STRB_W  packed per-requester byte strobes
done_o  out  N_REQ  one-hot one-cycle completion pulse
resp_o  out  2  response code, valid while any done_o bit is high
awid_o  out  ID_W  write address ID = grant index
awaddr_o  out  ADDR_W  write address
awvalid_o  out  1  write address valid
awready_i  in  1  write address ready
wdata_o  out  DATA_W  write data
wstrb_o  out  STRB_W  write strobes
wvalid_o  out  1  write data valid
wready_i  in  1  write data ready
bid_i  in  ID_W  response ID
bresp_i  in  2  response code
bvalid_i  in  1  response valid
bready_o  out  1  response ready

Behaviour:
- Reset (areset=0, asynchronous): state IDLE, rr pointer 0, all outputs 0 (req_ready_o, done_o, resp_o, awvalid_o, wvalid_o, bready_o, awid_o, awaddr_o, wdata_o, wstrb_o).
- States: IDLE -> XFER -> RESP -> IDLE.
- IDLE:
  - If any req_valid_i is set, combinationally grant the first set bit at or after the rr pointer, wrapping N_REQ-1 -> 0.
  - req_ready_o[g]=1 in that cycle.
  - Capture addr/data/strb/g into registers; go to XFER.
  - Set awvalid_o=1, wvalid_o=1 and awid_o=g from the next cycle.
- XFER:
  - awvalid_o drops the cycle after awvalid_o&&awready_i; wvalid_o drops the cycle after wvalid_o&&wready_i. The two handshakes are independent and may occur in either order or in the same cycle.
  - Payload registers stay stable while the corresponding valid is high.
  - When both handshakes are complete, go to RESP with bready_o=1 the following cycle.
- RESP:
  - bready_o held at 1. On bvalid_i&&bready_o: done_o[g]=1 for one cycle next cycle, resp_o=bresp_i, bready_o->0, state->IDLE.
  - If bid_i != awid_o, resp_o = 2'b10 (SLVERR) regardless of bresp_i.
  - rr pointer <= (g+1) mod N_REQ.
- Minimum cycle count request-accept to done_o with a zero-wait slave: 3 cycles (IDLE accept, XFER handshake, RESP handshake, done_o pulse on next edge).
- No new grant is issued in the cycle done_o is high; the next grant is possible the following cycle. Maximum throughput is one write per 4 cycles.
- A req_valid_i bit dropping before accept is legal and simply removes that requester from arbitration.
- A new req_valid_i from the currently-busy requester is not accepted until IDLE.
- Reset asserted mid-XFER/RESP aborts immediately:
  - all valids drop and no done_o is issued;
  - the slave must be reset together with this block.
- N_REQ=1 degenerates to a pass-through sequencer with a constant grant of 0.

Decomposition:
- Shared package axi_pkg: resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and wr_state_t enum (IDLE, XFER, RESP).
- One sub-module rr_arbiter (N parameter): req vector, pointer input, one-hot grant and binary index outputs, purely combinational.
- Pointer register and FSM live in axi_wr_arbiter.

Test Plan:
- Single write: req 0 valid with addr=32'h1, data=32'hABCDEFAC, strb=4'b1010; zero-wait slave -> AW/W carry those values, awid_o=0, done_o=4'b0001 with resp_o=OKAY 3 cycles after accept.
- Contention: requesters 0,2,3 valid simultaneously from reset -> grant order 0,2,3, then 0 again if re-asserted; req_ready_o is one-hot each time.
- Fairness: all 4 requesters held valid for 8 transactions -> grants 0,1,2,3,0,1,2,3.
- Back-pressure: slave asserts wready_i at cycle 1 and awready_i at cycle 5 -> wvalid_o drops after cycle 1, awvalid_o stays high with stable awaddr_o until cycle 5, then RESP. Also cover the reverse order and same-cycle handshakes.
- Error paths: bresp_i=2'b11 -> resp_o=2'b11. Correct bresp_i=OKAY but bid_i=3 while awid_o=1 -> resp_o=2'b10 on done_o[1].
- Reset mid-RESP: drop areset while bready_o=1 -> all outputs 0 immediately, no done_o. After release, a pending req 1 is granted first (pointer reset to 0, req 0 idle).
